// File: rtl/mult_pkg.sv
// Shared types and default widths for the multiplier / product accumulator datapath.
package mult_pkg;

  localparam int unsigned PROD_W = 8;
  localparam int unsigned ACC_W  = 16;

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_e;

endpackage

// File: rtl/product_accumulator_sat_add.sv
// Combinational ACC_W adder with carry out; clamps to all-ones when
// PRODUCT_ACCUMULATOR_SAT_EN is defined, otherwise wraps.
module sat_add #(
  parameter int unsigned ACC_W = 16
) (
  input  logic [ACC_W-1:0] a,
  input  logic [ACC_W-1:0] b,
  output logic [ACC_W-1:0] sum,
  output logic             carry
);

  logic [ACC_W:0] raw;

  always_comb begin
    raw   = {1'b0, a} + {1'b0, b};
    carry = raw[ACC_W];
`ifdef PRODUCT_ACCUMULATOR_SAT_EN
    sum   = raw[ACC_W] ? {ACC_W{1'b1}} : raw[ACC_W-1:0];
`else
    sum   = raw[ACC_W-1:0];
`endif
  end

endmodule

// File: rtl/product_accumulator.sv
// Sums COUNT consecutive products into one block result held on a valid/ready output.
// Optional saturating arithmetic via PRODUCT_ACCUMULATOR_SAT_EN (see sat_add).
module product_accumulator #(
  parameter int unsigned PROD_W = mult_pkg::PROD_W,
  parameter int unsigned ACC_W  = mult_pkg::ACC_W,
  parameter int unsigned COUNT  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PROD_W-1:0] in_prod,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_sum,
  output logic              out_ovf
);

  import mult_pkg::*;

  localparam int unsigned CntW = $clog2(COUNT + 1);
  localparam logic [CntW-1:0] LastCnt = CntW'(COUNT - 1);

  state_e          state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             ovf_q, ovf_d;

  logic [ACC_W-1:0] add_sum;
  logic             add_carry;
  logic             accept;
  logic             last;

  sat_add #(
    .ACC_W(ACC_W)
  ) u_sat_add (
    .a    (acc_q),
    .b    (ACC_W'(in_prod)),
    .sum  (add_sum),
    .carry(add_carry)
  );

  assign accept = in_valid && (state_q == ACCUM);
  assign last   = (cnt_q == LastCnt);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ACCUM;
      acc_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = ACCUM;
    end else begin
      unique case (state_q)
        ACCUM:   if (accept && last) state_d = HOLD;
        HOLD:    if (out_ready) state_d = ACCUM;
        default: state_d = ACCUM;
      endcase
    end
  end

  // Flush and result handshake both start a fresh block; a product offered with flush is dropped.
  always_comb begin
    acc_d = acc_q;
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    if (flush || (state_q == HOLD && out_ready)) begin
      acc_d = '0;
      cnt_d = '0;
      ovf_d = 1'b0;
    end else if (accept) begin
      acc_d = add_sum;
      cnt_d = cnt_q + CntW'(1);
      ovf_d = ovf_q | add_carry;
    end
  end

  always_comb begin
    in_ready  = (state_q == ACCUM);
    out_valid = (state_q == HOLD);
    out_sum   = acc_q;
    out_ovf   = ovf_q;
  end

endmodule

// File: tb/tb_product_accumulator.sv
// Directed, table-driven bench for product_accumulator (default build and ACC_W=9 overflow case).
module tb_product_accumulator;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_prod;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_sum;
  logic        out_ovf;

  logic        s_flush;
  logic        s_in_valid;
  logic        s_in_ready;
  logic [7:0]  s_in_prod;
  logic        s_out_valid;
  logic        s_out_ready;
  logic [8:0]  s_out_sum;
  logic        s_out_ovf;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  product_accumulator dut (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_prod  (in_prod),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_sum  (out_sum),
    .out_ovf  (out_ovf)
  );

  product_accumulator #(
    .PROD_W(8),
    .ACC_W (9),
    .COUNT (4)
  ) dut_small (
    .clk      (clk),
    .rst      (rst),
    .flush    (s_flush),
    .in_valid (s_in_valid),
    .in_ready (s_in_ready),
    .in_prod  (s_in_prod),
    .out_valid(s_out_valid),
    .out_ready(s_out_ready),
    .out_sum  (s_out_sum),
    .out_ovf  (s_out_ovf)
  );

  typedef struct {
    logic [3:0][7:0] prods;
    int              gap;
    logic            early_rdy;
    logic [15:0]     sum;
    logic            ovf;
  } vec_t;

  vec_t tbl [6];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Offers four products; optional idle gap after the first one.
  task automatic feed(input logic [3:0][7:0] p, input int gap_after);
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_prod  = p[i];
      chk("in_ready_accum", in_ready, 1);
      tick();
      if (i == 0) begin
        for (int g = 0; g < gap_after; g++) begin
          in_valid = 1'b0;
          in_prod  = 8'hAA;
          tick();
          chk("stall_no_valid", out_valid, 0);
        end
      end
    end
    in_valid = 1'b0;
    in_prod  = 8'h00;
  endtask

  initial begin
    tbl[0] = '{prods: {8'd1, 8'd45, 8'd12, 8'd6}, gap: 0, early_rdy: 1'b1, sum: 16'd64, ovf: 1'b0};
    tbl[1] = '{prods: {8'd225, 8'd225, 8'd225, 8'd225}, gap: 3, early_rdy: 1'b0, sum: 16'd900,
               ovf: 1'b0};
    tbl[2] = '{prods: {8'd255, 8'd255, 8'd255, 8'd255}, gap: 0, early_rdy: 1'b1, sum: 16'd1020,
               ovf: 1'b0};
    tbl[3] = '{prods: {8'd0, 8'd0, 8'd0, 8'd0}, gap: 1, early_rdy: 1'b0, sum: 16'd0, ovf: 1'b0};
    tbl[4] = '{prods: {8'd4, 8'd3, 8'd2, 8'd1}, gap: 0, early_rdy: 1'b0, sum: 16'd10, ovf: 1'b0};
    tbl[5] = '{prods: {8'd200, 8'd0, 8'd17, 8'd0}, gap: 2, early_rdy: 1'b1, sum: 16'd217,
               ovf: 1'b0};

    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_prod = '0; out_ready = 1'b0;
    s_flush = 1'b0; s_in_valid = 1'b0; s_in_prod = '0; s_out_ready = 1'b0;
    tick();
    tick();
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_sum", out_sum, 0);
    chk("rst_out_ovf", out_ovf, 0);
    rst = 1'b0;

    for (int v = 0; v < 6; v++) begin
      out_ready = tbl[v].early_rdy;
      feed(tbl[v].prods, tbl[v].gap);
      chk("blk_out_valid", out_valid, 1);
      chk("blk_in_ready", in_ready, 0);
      chk("blk_out_sum", out_sum, tbl[v].sum);
      chk("blk_out_ovf", out_ovf, tbl[v].ovf);
      out_ready = 1'b1;
      tick();
      chk("blk_done_in_ready", in_ready, 1);
      chk("blk_done_out_valid", out_valid, 0);
      out_ready = 1'b0;
    end

    // Back-pressure; products offered during HOLD must be ignored.
    feed({8'd1, 8'd45, 8'd12, 8'd6}, 0);
    for (int c = 0; c < 5; c++) begin
      in_valid = 1'b1;
      in_prod  = 8'd99;
      tick();
      chk("bp_out_valid", out_valid, 1);
      chk("bp_out_sum", out_sum, 64);
      chk("bp_in_ready", in_ready, 0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    chk("bp_rel_in_ready", in_ready, 1);
    chk("bp_rel_acc", out_sum, 0);
    out_ready = 1'b0;

    // Flush mid-block, with a product offered in the flush cycle.
    in_valid = 1'b1; in_prod = 8'd100;
    tick();
    tick();
    flush = 1'b1; in_prod = 8'd50;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_part_acc", out_sum, 0);
    chk("flush_part_in_ready", in_ready, 1);
    feed({8'd1, 8'd45, 8'd12, 8'd6}, 0);
    chk("flush_next_valid", out_valid, 1);
    chk("flush_next_sum", out_sum, 64);

    // Flush during HOLD discards the result.
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_hold_valid", out_valid, 0);
    chk("flush_hold_sum", out_sum, 0);
    out_ready = 1'b1;
    tick();
    tick();
    chk("flush_hold_stays_idle", out_valid, 0);
    chk("flush_hold_in_ready", in_ready, 1);
    out_ready = 1'b0;

    // Overflow on the ACC_W=9 instance: 225, 225, 225, 1.
    for (int i = 0; i < 4; i++) begin
      s_in_valid = 1'b1;
      s_in_prod  = (i == 3) ? 8'd1 : 8'd225;
      tick();
    end
    s_in_valid = 1'b0;
    chk("ovf_out_valid", s_out_valid, 1);
`ifdef PRODUCT_ACCUMULATOR_SAT_EN
    chk("ovf_out_sum", s_out_sum, 511);
`else
    chk("ovf_out_sum", s_out_sum, 164);
`endif
    chk("ovf_out_ovf", s_out_ovf, 1);
    s_out_ready = 1'b1;
    tick();
    chk("ovf_cleared", s_out_ovf, 0);
    chk("ovf_in_ready", s_in_ready, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
